// File: rtl/mem_responder.sv
// mem_responder: single-port word-addressed memory target with a fixed-latency
// request/response handshake.
//
// A request is accepted in IDLE when req_valid is high. The request fields are
// captured, the responder spends WAIT_CYCLES cycles in WAIT, then presents a
// one-cycle response in RESP and returns to IDLE. Misaligned or out-of-range
// addresses are rejected with resp_err and never touch storage.
//
// Parameters:
//   WAIT_CYCLES - wait-state cycles between acceptance and the response
//   DEPTH_LOG2  - log2 of the number of 32-bit words in storage
//
// Ports:
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous active-low reset
//   req_valid  - request present
//   req_ready  - responder is in IDLE and can accept
//   req_wr     - 1 = write, 0 = read
//   req_addr   - byte address
//   req_wdata  - write data
//   req_be     - byte-lane enables for writes
//   resp_valid - one-cycle response strobe
//   resp_rdata - read data, or the post-write word for writes (0 on error)
//   resp_err   - request rejected
module mem_responder #(
    parameter int WAIT_CYCLES = 2,
    parameter int DEPTH_LOG2  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic        wr_reg;
    logic [31:0] addr_reg;
    logic [31:0] wdata_reg;
    logic [3:0]  be_reg;

    logic [31:0] rdata_reg;
    logic        err_reg;

    logic [31:0] mem [DEPTH];

    logic                  accept;
    logic                  enter_resp;
    logic                  op_wr;
    logic [31:0]           op_addr;
    logic [31:0]           op_wdata;
    logic [3:0]            op_be;
    logic                  op_err;
    logic [DEPTH_LOG2-1:0] op_idx;
    logic [31:0]           cur_word;
    logic [31:0]           merged_word;

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_err   = err_reg;

    assign accept = (state_reg == IDLE) && req_valid;

    // With WAIT_CYCLES=0 the response is produced on the accepting edge itself,
    // before the capture registers hold the request, so the live inputs are
    // used while in IDLE and the captured copy otherwise.
    assign op_wr    = (state_reg == IDLE) ? req_wr    : wr_reg;
    assign op_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
    assign op_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
    assign op_be    = (state_reg == IDLE) ? req_be    : be_reg;

    assign op_err = (op_addr[1:0] != 2'b00) ||
                    ((op_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
    assign op_idx = op_addr[DEPTH_LOG2+1:2];

    // Asynchronous read so the read-modify-write completes on the single edge
    // that enters RESP.
    assign cur_word = mem[op_idx];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_word[8*gi +: 8] = op_be[gi] ? op_wdata[8*gi +: 8]
                                                      : cur_word[8*gi +: 8];
        end
    endgenerate

    assign enter_resp = ((state_reg == IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                        ((state_reg == WAIT) && (cnt_reg == CNT_W'(1)));

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            wr_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                wr_reg    <= req_wr;
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                be_reg    <= req_be;
            end
            if (enter_resp) begin
                err_reg <= op_err;
                if (op_err) begin
                    rdata_reg <= '0;
                end else if (op_wr) begin
                    rdata_reg <= merged_word;
                end else begin
                    rdata_reg <= cur_word;
                end
            end
        end
    end

    // Storage is never cleared. The reset term keeps an edge that coincides
    // with an asserted reset from committing an abandoned write.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && op_wr && !op_err) begin
            mem[op_idx] <= merged_word;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks for mem_responder.
// dut uses WAIT_CYCLES=2; dut_z uses WAIT_CYCLES=0 for the back-to-back cadence.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        req_valid, req_wr, req_ready, resp_valid, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic [3:0]  req_be;

    logic        z_req_valid, z_req_wr, z_req_ready, z_resp_valid, z_resp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;
    logic [3:0]  z_req_be;

    int checks = 0;
    int errors = 0;

    mem_responder #(.WAIT_CYCLES(2), .DEPTH_LOG2(8)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err)
    );

    mem_responder #(.WAIT_CYCLES(0), .DEPTH_LOG2(8)) dut_z (
        .clk       (clk),
        .reset     (rst_n),
        .req_valid (z_req_valid),
        .req_ready (z_req_ready),
        .req_wr    (z_req_wr),
        .req_addr  (z_req_addr),
        .req_wdata (z_req_wdata),
        .req_be    (z_req_be),
        .resp_valid(z_resp_valid),
        .resp_rdata(z_resp_rdata),
        .resp_err  (z_resp_err)
    );

    // Drives one request on dut, scrambles the inputs after acceptance,
    // and reports the response and how many edges after acceptance it came.
    task automatic transact(input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            output logic [31:0] rdata, output logic err,
                            output int lat, output logic pulse_ok,
                            output logic hold_ok);
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wr    = ~wr;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        req_be    = ~be;
        lat = -1;
        for (int i = 0; i <= 12; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (resp_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
        rdata    = resp_rdata;
        err      = resp_err;
        pulse_ok = 1'b0;
        hold_ok  = 1'b0;
        if (lat >= 0) begin
            @(posedge clk);
            #1;
            pulse_ok = (resp_valid === 1'b0);
            hold_ok  = (resp_rdata === rdata) && (resp_err === err);
        end
        $display("txn wr=%0d addr=%08h wdata=%08h be=%h -> rdata=%08h err=%0d lat=%0d",
                 wr, addr, wdata, be, rdata, err, lat);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %08h want 00000000", resp_rdata); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", resp_err); end
        checks++; if (z_req_ready !== 1'b1 || z_resp_valid !== 1'b0) begin errors++; $display("FAIL reset_z got ready=%b valid=%b want 1 0", z_req_ready, z_resp_valid); end
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_addr  = 32'h0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL accept_first_edge got ready=%b want 0", req_ready); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er, pok, hok; int lat;
        transact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr10_rdata got %08h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr10_err got %b want 0", er); end
        checks++; if (lat != 2) begin errors++; $display("FAIL wr10_latency got %0d want 2", lat); end
        checks++; if (pok !== 1'b1) begin errors++; $display("FAIL wr10_one_cycle got %b want 1", pok); end
        checks++; if (hok !== 1'b1) begin errors++; $display("FAIL wr10_hold got %b want 1", hok); end
        transact(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL rd10_rdata got %08h want deadbeef", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL rd10_err got %b want 0", er); end
        checks++; if (lat != 2) begin errors++; $display("FAIL rd10_latency got %0d want 2", lat); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; logic er, pok, hok; int lat;
        transact(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'h11223344) begin errors++; $display("FAIL wr20_full got %08h want 11223344", rd); end
        transact(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL wr20_be5 got %08h want 11bb33dd", rd); end
        checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr20_be5_err got %b want 0", er); end
        transact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL rd20 got %08h want 11bb33dd", rd); end
        transact(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'h11BB33DD || er !== 1'b0) begin errors++; $display("FAIL wr20_be0 got %08h err=%b want 11bb33dd err=0", rd, er); end
        transact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL rd20_after_be0 got %08h want 11bb33dd", rd); end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er, pok, hok; int lat;
        transact(1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, lat, pok, hok);
        transact(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL rd22_misaligned got err=%b rdata=%08h want 1 00000000", er, rd); end
        transact(1'b1, 32'h400, 32'h55555555, 4'hF, rd, er, lat, pok, hok);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL wr400_range got err=%b rdata=%08h want 1 00000000", er, rd); end
        checks++; if (lat != 2) begin errors++; $display("FAIL wr400_latency got %0d want 2", lat); end
        transact(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin errors++; $display("FAIL rd0_unchanged got %08h err=%b want cafef00d 0", rd, er); end
        transact(1'b1, 32'h23, 32'h99999999, 4'hF, rd, er, lat, pok, hok);
        checks++; if (er !== 1'b1) begin errors++; $display("FAIL wr23_err got %b want 1", er); end
        transact(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL rd20_after_err got %08h want 11bb33dd", rd); end
        transact(1'b0, 32'h80000010, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (er !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL rd_high_addr got err=%b rdata=%08h want 1 00000000", er, rd); end
    endtask

    task automatic test_capture();
        logic [31:0] rd; logic er, pok, hok; int lat;
        transact(1'b1, 32'h48, 32'h48484848, 4'hF, rd, er, lat, pok, hok);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h44; req_wdata = 32'h44444444; req_be = 4'hF;
        @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL wait_ready got %b want 0", req_ready); end
        req_addr = 32'h48; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h44444444 || resp_err !== 1'b0) begin
            errors++; $display("FAIL capture_resp got valid=%b rdata=%08h err=%b want 1 44444444 0", resp_valid, resp_rdata, resp_err);
        end
        $display("txn wr=1 addr=00000044 wdata=44444444 be=f -> rdata=%08h err=%0d (inputs changed in WAIT)", resp_rdata, resp_err);
        @(posedge clk);
        #1;
        transact(1'b0, 32'h44, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'h44444444) begin errors++; $display("FAIL rd44 got %08h want 44444444", rd); end
        transact(1'b0, 32'h48, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'h48484848) begin errors++; $display("FAIL rd48 got %08h want 48484848", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er, pok, hok; int lat;
        logic saw;
        transact(1'b1, 32'h30, 32'h0BADF00D, 4'hF, rd, er, lat, pok, hok);
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", resp_valid); end
        checks++; if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin errors++; $display("FAIL midrst_resp got rdata=%08h err=%b want 00000000 0", resp_rdata, resp_err); end
        saw = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) saw = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (resp_valid === 1'b1) saw = 1'b1;
        end
        checks++; if (saw !== 1'b0) begin errors++; $display("FAIL midrst_no_strobe got %b want 0", saw); end
        $display("txn wr=1 addr=00000030 wdata=ffffffff be=f -> abandoned by reset");
        transact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat, pok, hok);
        checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rd30_after_reset got %08h want 0badf00d", rd); end
    endtask

    task automatic test_back_to_back();
        int pulses;
        logic exp_v;
        @(negedge clk);
        z_req_valid = 1'b1; z_req_wr = 1'b1; z_req_addr = 32'h50; z_req_be = 4'hF;
        z_req_wdata = 32'hA0000000;
        pulses = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            exp_v = ((k % 2) == 0);
            checks++; if (z_resp_valid !== exp_v) begin errors++; $display("FAIL b2b_valid[%0d] got %b want %b", k, z_resp_valid, exp_v); end
            checks++; if (z_req_ready !== !exp_v) begin errors++; $display("FAIL b2b_ready[%0d] got %b want %b", k, z_req_ready, !exp_v); end
            if (z_resp_valid === 1'b1) begin
                pulses++;
                checks++; if (z_resp_rdata !== 32'hA0000000 + k) begin errors++; $display("FAIL b2b_rdata[%0d] got %08h want %08h", k, z_resp_rdata, 32'hA0000000 + k); end
                $display("txn z wr=1 addr=00000050 -> rdata=%08h err=%0d", z_resp_rdata, z_resp_err);
            end
            @(negedge clk);
            z_req_wdata = 32'hA0000000 + k + 1;
        end
        z_req_valid = 1'b0;
        checks++; if (pulses != 4) begin errors++; $display("FAIL b2b_pulses got %0d want 4", pulses); end
        @(negedge clk);
        z_req_valid = 1'b1; z_req_wr = 1'b0; z_req_addr = 32'h50;
        @(posedge clk);
        #1;
        checks++; if (z_resp_valid !== 1'b1 || z_resp_rdata !== 32'hA0000006) begin
            errors++; $display("FAIL z_rd50 got valid=%b rdata=%08h want 1 a0000006", z_resp_valid, z_resp_rdata);
        end
        $display("txn z wr=0 addr=00000050 -> rdata=%08h err=%0d", z_resp_rdata, z_resp_err);
        @(negedge clk);
        z_req_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        z_req_valid = 1'b0; z_req_wr = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_req_be = '0;
        test_reset();
        test_write_read();
        test_byte_lanes();
        test_errors();
        test_capture();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
